// File: rtl/traffic_light_ctrl.sv
// Multi-approach traffic-light sequencer: round-robin green/amber/all-red, pedestrian cut-in, night flash.
// Lamps are active-low, outputs registered and aligned with the state transition.
module traffic_light_ctrl #(
  parameter int N_CH            = 4,
  parameter int PRESCALE        = 27_000_000,
  parameter int GREEN_TICKS     = 40,
  parameter int AMBER_TICKS     = 5,
  parameter int ALLRED_TICKS    = 2,
  parameter int MIN_GREEN_TICKS = 10,
  parameter int PED_TICKS       = 15,
  parameter int FLASH_TICKS     = 1,
  localparam int CH_W           = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic                night_mode,
  input  logic                ped_req,
  output logic [3*N_CH-1:0]   led,
  output logic [CH_W-1:0]     active_ch,
  output logic [2:0]          phase,
  output logic                ped_walk,
  output logic                ped_pending
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAX_T = max2(max2(max2(GREEN_TICKS, AMBER_TICKS), max2(ALLRED_TICKS, MIN_GREEN_TICKS)),
                              max2(PED_TICKS, FLASH_TICKS));
  localparam int TMR_W = $clog2(MAX_T) + 1;
  localparam int PS_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [PS_W-1:0]  PS_LAST = PS_W'(PRESCALE - 1);
  localparam logic [TMR_W-1:0] G_LAST  = TMR_W'(GREEN_TICKS - 1);
  localparam logic [TMR_W-1:0] A_LAST  = TMR_W'(AMBER_TICKS - 1);
  localparam logic [TMR_W-1:0] R_LAST  = TMR_W'(ALLRED_TICKS - 1);
  localparam logic [TMR_W-1:0] MG_LAST = TMR_W'(MIN_GREEN_TICKS - 1);
  localparam logic [TMR_W-1:0] P_LAST  = TMR_W'(PED_TICKS - 1);
  localparam logic [TMR_W-1:0] F_LAST  = TMR_W'(FLASH_TICKS - 1);
  localparam logic [CH_W-1:0]  CH_LAST = CH_W'(N_CH - 1);

  if (N_CH < 1 || N_CH > 8 || PRESCALE < 1 || GREEN_TICKS < 1 || AMBER_TICKS < 1 ||
      ALLRED_TICKS < 1 || MIN_GREEN_TICKS < 1 || PED_TICKS < 1 || FLASH_TICKS < 1 ||
      MIN_GREEN_TICKS > GREEN_TICKS) begin : g_bad_params
    $error("traffic_light_ctrl: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    ST_ALL_RED = 3'd0,
    ST_GREEN   = 3'd1,
    ST_AMBER   = 3'd2,
    ST_PED     = 3'd3,
    ST_FLASH   = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [CH_W-1:0]    ch_q, ch_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [PS_W-1:0]    presc_q, presc_d;
  logic               ped_q, ped_d;
  logic               flash_q, flash_d;
  logic [3*N_CH-1:0]  led_q, led_d;
  logic [2:0]         phase_q, phase_d;
  logic               walk_q, walk_d;
  logic               tick;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ST_ALL_RED;
      ch_q    <= '0;
      tmr_q   <= '0;
      presc_q <= '0;
      ped_q   <= 1'b0;
      flash_q <= 1'b0;
      led_q   <= {N_CH{3'b101}};
      phase_q <= 3'd0;
      walk_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      tmr_q   <= tmr_d;
      presc_q <= presc_d;
      ped_q   <= ped_d;
      flash_q <= flash_d;
      led_q   <= led_d;
      phase_q <= phase_d;
      walk_q  <= walk_d;
    end
  end

  always_comb begin
    tick    = (presc_q == PS_LAST);
    presc_d = tick ? '0 : presc_q + 1'b1;
    state_d = state_q;
    ch_d    = ch_q;
    flash_d = flash_q;
    tmr_d   = tick ? tmr_q + 1'b1 : tmr_q;
    ped_d   = ped_q | ped_req;

    case (state_q)
      ST_ALL_RED: begin
        if (tick && tmr_q == R_LAST) begin
          if (night_mode)  state_d = ST_FLASH;
          else if (ped_q)  state_d = ST_PED;
          else             state_d = ST_GREEN;
        end
      end
      ST_GREEN: begin
        if (tick && (tmr_q == G_LAST || (ped_q && tmr_q >= MG_LAST))) state_d = ST_AMBER;
      end
      ST_AMBER: begin
        if (tick && tmr_q == A_LAST) begin
          if (night_mode) begin
            state_d = ST_FLASH;
          end else begin
            state_d = ST_ALL_RED;
            ch_d    = (ch_q == CH_LAST) ? '0 : ch_q + 1'b1;
          end
        end
      end
      ST_PED: begin
        if (tick && tmr_q == P_LAST) begin
          ped_d   = ped_req;
          state_d = night_mode ? ST_FLASH : ST_GREEN;
        end
      end
      ST_FLASH: begin
        if (tick) begin
          if (!night_mode) begin
            state_d = ST_ALL_RED;
            ch_d    = '0;
            flash_d = 1'b0;
          end else if (tmr_q == F_LAST) begin
            flash_d = ~flash_q;
            tmr_d   = '0;
          end
        end
      end
      default: state_d = ST_ALL_RED;
    endcase

    if (state_d != state_q) tmr_d = '0;
    // Pedestrian requests are meaningless while flashing; also drops a latch pending at flash entry.
    if (state_q == ST_FLASH || state_d == ST_FLASH) ped_d = 1'b0;

    for (int c = 0; c < N_CH; c++) begin
      led_d[3*c +: 3] = 3'b101;
      if (state_d == ST_GREEN && ch_d == CH_W'(c)) led_d[3*c +: 3] = 3'b110;
      if (state_d == ST_AMBER && ch_d == CH_W'(c)) led_d[3*c +: 3] = 3'b011;
      if (state_d == ST_FLASH) led_d[3*c +: 3] = flash_d ? 3'b011 : 3'b111;
    end
    phase_d = state_d;
    walk_d  = (state_d == ST_PED);
  end

  assign led         = led_q;
  assign active_ch   = ch_q;
  assign phase       = phase_q;
  assign ped_walk    = walk_q;
  assign ped_pending = ped_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Bench for traffic_light_ctrl: scoreboarded reference model plus directed spot checks,
// and a second instance with one channel and a one-clock tick.
module tb_traffic_light_ctrl;

  localparam int P = 4, N = 3, G = 5, A = 2, R = 1, MG = 2, PT = 3, F = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        night_mode = 1'b0;
  logic        ped_req = 1'b0;
  logic [8:0]  led;
  logic [1:0]  active_ch;
  logic [2:0]  phase;
  logic        ped_walk, ped_pending;

  logic        rst2_n = 1'b0;
  logic        night2 = 1'b0;
  logic        ped2 = 1'b0;
  logic [2:0]  led2;
  logic [0:0]  ch2;
  logic [2:0]  phase2;
  logic        walk2, pend2;

  always #5 clk = ~clk;

  traffic_light_ctrl #(
    .N_CH(N), .PRESCALE(P), .GREEN_TICKS(G), .AMBER_TICKS(A), .ALLRED_TICKS(R),
    .MIN_GREEN_TICKS(MG), .PED_TICKS(PT), .FLASH_TICKS(F)
  ) dut (
    .sys_clk(clk), .sys_rst_n(rst_n), .night_mode(night_mode), .ped_req(ped_req),
    .led(led), .active_ch(active_ch), .phase(phase), .ped_walk(ped_walk), .ped_pending(ped_pending)
  );

  traffic_light_ctrl #(
    .N_CH(1), .PRESCALE(1), .GREEN_TICKS(G), .AMBER_TICKS(A), .ALLRED_TICKS(R),
    .MIN_GREEN_TICKS(MG), .PED_TICKS(PT), .FLASH_TICKS(F)
  ) dut1 (
    .sys_clk(clk), .sys_rst_n(rst2_n), .night_mode(night2), .ped_req(ped2),
    .led(led2), .active_ch(ch2), .phase(phase2), .ped_walk(walk2), .ped_pending(pend2)
  );

  typedef struct packed {
    logic [8:0] led;
    logic [2:0] ph;
    logic [1:0] ch;
    logic       walk;
    logic       pend;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_miss = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: counts remaining ticks per state downward.
  int m_st, m_ch, m_left, m_cnt;
  bit m_ped, m_fl;

  function automatic int st_len(input int st);
    case (st)
      0: return R;
      1: return G;
      2: return A;
      3: return PT;
      default: return F;
    endcase
  endfunction

  function automatic logic [8:0] lamps(input int st, input int ch, input bit fl);
    logic [8:0] v;
    for (int c = 0; c < N; c++) begin
      v[3*c +: 3] = 3'b101;
      if (st == 1 && c == ch) v[3*c +: 3] = 3'b110;
      if (st == 2 && c == ch) v[3*c +: 3] = 3'b011;
      if (st == 4) v[3*c +: 3] = fl ? 3'b011 : 3'b111;
    end
    return v;
  endfunction

  task automatic model_reset();
    m_st = 0; m_ch = 0; m_left = R; m_cnt = 0; m_ped = 0; m_fl = 0;
  endtask

  task automatic model_step(input bit nm, input bit pr, output exp_t e);
    bit tk, reload, nped;
    int nst;
    tk = (m_cnt == P - 1);
    m_cnt = tk ? 0 : m_cnt + 1;
    nst = m_st;
    nped = m_ped | pr;
    reload = 0;
    if (tk) begin
      case (m_st)
        0: if (m_left == 1) nst = nm ? 4 : (m_ped ? 3 : 1);
        1: if (m_left == 1 || (m_ped && (G - m_left) >= MG - 1)) nst = 2;
        2: if (m_left == 1) begin
             if (nm) nst = 4;
             else begin nst = 0; m_ch = (m_ch + 1) % N; end
           end
        3: if (m_left == 1) begin nped = pr; nst = nm ? 4 : 1; end
        default: begin
          if (!nm) begin nst = 0; m_ch = 0; m_fl = 0; end
          else if (m_left == 1) begin m_fl = !m_fl; m_left = F; reload = 1; end
        end
      endcase
    end
    if (nst != m_st) m_left = st_len(nst);
    else if (tk && !reload) m_left--;
    if (m_st == 4 || nst == 4) nped = 0;
    m_st = nst;
    m_ped = nped;
    e.led = lamps(m_st, m_ch, m_fl);
    e.ph = 3'(m_st);
    e.ch = 2'(m_ch);
    e.walk = (m_st == 3);
    e.pend = m_ped;
  endtask

  // Entered and left at a negedge; DUT outputs are compared 1 ns after the posedge.
  task automatic cycle(input bit nm, input bit pr);
    exp_t e;
    night_mode = nm;
    ped_req = pr;
    model_step(nm, pr, e);
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check_eq("sb_underflow", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check_eq("led", 32'(led), 32'(e.led));
      check_eq("phase", 32'(phase), 32'(e.ph));
      check_eq("active_ch", 32'(active_ch), 32'(e.ch));
      check_eq("ped_walk", 32'(ped_walk), 32'(e.walk));
      check_eq("ped_pending", 32'(ped_pending), 32'(e.pend));
    end
    @(negedge clk);
  endtask

  task automatic run(input int n, input bit nm, input bit pr);
    for (int i = 0; i < n; i++) cycle(nm, pr);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    night_mode = 1'b0;
    ped_req = 1'b0;
    #1;
    check_eq("rst_led", 32'(led), 32'h16D);
    check_eq("rst_phase", 32'(phase), 32'd0);
    check_eq("rst_ch", 32'(active_ch), 32'd0);
    check_eq("rst_pend", 32'(ped_pending), 32'd0);
    check_eq("rst_walk", 32'(ped_walk), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    sb.delete();
  endtask

  task automatic free_run_checks();
    do_reset();
    run(3, 0, 0);
    check_eq("s1_allred_hold", 32'(phase), 32'd0);
    run(1, 0, 0);
    check_eq("s1_ch0_green", 32'(led), 32'b101101110);
    run(19, 0, 0);
    check_eq("s1_green_hold", 32'(phase), 32'd1);
    run(1, 0, 0);
    check_eq("s1_ch0_amber", 32'(led), 32'b101101011);
    run(8, 0, 0);
    check_eq("s1_allred", 32'(led), 32'b101101101);
    run(4, 0, 0);
    check_eq("s1_ch1_green", 32'(led), 32'b101110101);
    check_eq("s1_ch1_idx", 32'(active_ch), 32'd1);
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);

    // Free run through a full rotation including the ch2 -> ch0 wrap.
    free_run_checks();
    run(64, 0, 0);
    check_eq("s1_wrap_ch0", 32'(active_ch), 32'd0);
    check_eq("s1_wrap_green", 32'(led), 32'b101101110);

    // Single-clock pedestrian press one tick into ch0 green.
    do_reset();
    run(10, 0, 0);
    run(1, 0, 1);
    check_eq("ped_latched", 32'(ped_pending), 32'd1);
    run(1, 0, 0);
    check_eq("ped_cut_amber", 32'(phase), 32'd2);
    run(8, 0, 0);
    check_eq("ped_allred", 32'(phase), 32'd0);
    run(4, 0, 0);
    check_eq("ped_phase", 32'(phase), 32'd3);
    check_eq("ped_walk_on", 32'(ped_walk), 32'd1);
    check_eq("ped_lamps", 32'(led), 32'b101101101);
    run(12, 0, 0);
    check_eq("ped_then_ch1", 32'(led), 32'b101110101);
    check_eq("ped_cleared", 32'(ped_pending), 32'd0);

    // Held request across a PED exit keeps the latch and earns a second walk.
    run(100, 0, 1);
    check_eq("ped_held_pend", 32'(ped_pending), 32'd1);
    run(60, 0, 0);

    // Night mode mid-green on ch1, with button presses ignored while flashing.
    do_reset();
    run(36, 0, 0);
    run(28, 1, 0);
    check_eq("night_flash", 32'(phase), 32'd4);
    check_eq("night_dark", 32'(led), 32'b111111111);
    run(8, 1, 0);
    check_eq("night_lit", 32'(led), 32'b011011011);
    run(3, 1, 1);
    check_eq("night_ped_ign", 32'(ped_pending), 32'd0);
    run(1, 1, 0);
    run(4, 0, 0);
    check_eq("night_exit_red", 32'(phase), 32'd0);
    check_eq("night_exit_ch0", 32'(active_ch), 32'd0);
    run(4, 0, 0);
    check_eq("night_exit_green", 32'(led), 32'b101101110);

    // Asynchronous reset during ch2 amber, then the reset sequence again.
    do_reset();
    run(90, 0, 0);
    check_eq("pre_rst_amber", 32'(phase), 32'd2);
    check_eq("pre_rst_ch2", 32'(active_ch), 32'd2);
    free_run_checks();

    // One channel, tick every clock: 5/2/1 clock cycle with no channel advance.
    rst2_n = 1'b0;
    #1;
    check_eq("n1_rst_led", 32'(led2), 32'b101);
    @(negedge clk);
    rst2_n = 1'b1;
    for (int k = 0; k < 24; k++) begin
      int pos;
      logic [2:0] eph, eled;
      @(posedge clk);
      #1;
      pos = k % 8;
      eph = (pos < 5) ? 3'd1 : ((pos < 7) ? 3'd2 : 3'd0);
      eled = (eph == 3'd1) ? 3'b110 : ((eph == 3'd2) ? 3'b011 : 3'b101);
      check_eq("n1_phase", 32'(phase2), 32'(eph));
      check_eq("n1_led", 32'(led2), 32'(eled));
      check_eq("n1_ch", 32'(ch2), 32'd0);
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/traffic_light_ctrl.md
Name: traffic_light_ctrl

Overview:
- Parametrised multi-approach traffic-light sequencer. Drives N_CH RGB-style lamp groups (active-low) from a shared tick prescaler.
- Round-robin green with amber and all-red clearance, plus a latched pedestrian request that cuts green short and a night-mode flashing amber.
- Sits between the board clock/reset and the lamp pins. Replaces the single-lamp fixed-count sequencer.

Parameters:
- N_CH, 4, number of approaches (lamp groups), 1..8
- PRESCALE, 27_000_000, sys_clk cycles per tick (1 s at 27 MHz)
- GREEN_TICKS, 40, green duration in ticks
- AMBER_TICKS, 5, amber duration in ticks
- ALLRED_TICKS, 2, all-red clearance in ticks
- MIN_GREEN_TICKS, 10, minimum green before a pedestrian request may cut it
- PED_TICKS, 15, pedestrian walk duration in ticks
- FLASH_TICKS, 1, half-period of the night-mode amber flash in ticks

Ports:
- sys_clk  in  1  system clock
- sys_rst_n  in  1  reset, asynchronous, active-low
- night_mode  in  1  level; 1 requests flashing-amber mode
- ped_req  in  1  pedestrian button; synchronous, one or more cycles high
- led  out  3*N_CH  per channel c: led[3c+0]=green, [3c+1]=red, [3c+2]=amber; active-low (0 = lit)
- active_ch  out  $clog2(N_CH) (min 1)  channel currently owning green/amber
- phase  out  3  0=ALL_RED, 1=GREEN, 2=AMBER, 3=PED, 4=FLASH
- ped_walk  out  1  high during PED phase
- ped_pending  out  1  pedestrian request latched, not yet served

Behaviour:
- Reset (async, sys_rst_n=0): state ALL_RED, active_ch=0, timer=0, prescaler=0, ped latch=0, ped_walk=0, flash bit=0. Every channel is 3'b101 (red lit), so led = {N_CH{3'b101}}.
- Prescaler: counts 0..PRESCALE-1 and wraps. tick=1 for one clock when it equals PRESCALE-1. It free-runs and is never cleared by state changes.
- State timer: cleared on every state entry. Increments on tick. A state of length L exits on the tick where timer==L-1, so it lasts exactly L ticks.
- Outputs are registered and update on the same sys_clk edge as the state transition.
- Transitions:
  - ALL_RED: on expiry, go to PED if the ped latch is set, else to GREEN.
  - GREEN: on expiry, go to AMBER. Also go to AMBER early on the tick where the ped latch is set and timer >= MIN_GREEN_TICKS-1.
  - AMBER: on expiry, go to ALL_RED with active_ch advanced (N_CH-1 wraps to 0). If night_mode=1 at expiry, go to FLASH instead.
  - PED: on expiry, clear the ped latch and go to GREEN for the current active_ch. PED never advances the channel.
  - FLASH: on expiry of each FLASH_TICKS half-period, toggle the flash bit. When night_mode=0 at a tick boundary, go to ALL_RED with active_ch=0.
- night_mode seen in ALL_RED or PED: go to FLASH at that state's expiry. night_mode seen in GREEN: finish green and amber normally, then go to FLASH.
- Lamp decode:
  - ALL_RED and PED: all channels 101.
  - GREEN: active_ch=110, others 101.
  - AMBER: active_ch=011, others 101.
  - FLASH: all channels 011 when the flash bit is 1, else 111 (dark).
- Ped latch:
  - Set on any clock with ped_req=1. Level-held ped_req sets it only once.
  - Cleared only on PED exit. If ped_req=1 on the PED-exit clock, the latch stays set (set wins).
  - Ignored and held at 0 while in FLASH.
  - ped_pending = latch.
- Simultaneous ped latch and night_mode at ALL_RED expiry: night_mode wins (go to FLASH) and the latch is cleared.
- Reset mid-operation: immediate return to the reset state. No partial tick carries over.
- Width rules: timer width is $clog2 of the largest *_TICKS parameter plus 1. Prescaler width is $clog2(PRESCALE).
- Elaboration error if any *_TICKS < 1, MIN_GREEN_TICKS > GREEN_TICKS, or N_CH < 1.

Test Plan (PRESCALE=4, N_CH=3, GREEN=5, AMBER=2, ALLRED=1, MIN_GREEN=2, PED=3, FLASH=2):
- Reset then free run:
  - led=101101101, phase=0 for 4 clocks.
  - Then ch0=110 for 20 clocks, ch0=011 for 8 clocks, all-red 4 clocks, then ch1 green.
  - ch2 is followed by ch0 (wrap).
- ped_req pulse 1 clock, 1 tick into ch0 green:
  - Green ends at timer==1 (2 ticks total), then amber 2 ticks, all-red 1 tick.
  - PED 3 ticks with ped_walk=1 and all 101, then ch1 green. ped_pending falls on PED exit.
- ped_req held high for 100 clocks across a PED exit -> ped_pending remains 1 and a second PED follows the next all-red.
- night_mode=1 asserted mid-green on ch1:
  - Green completes, then amber, then FLASH.
  - led alternates 111111111 and 011011011 every 8 clocks. ped_req is ignored.
  - Drop night_mode -> all-red, then ch0 green.
- sys_rst_n pulsed low during AMBER on ch2 -> led=101101101, active_ch=0, ped_pending=0, and the sequence restarts exactly as in scenario 1.
- N_CH=1, PRESCALE=1 -> green/amber/all-red cycle with no channel advance, 5/2/1 clocks; no X on active_ch.
